vexp_sum_reduce: RTL

//  Downstream consumer of the vector exp unit. Accumulates a stream of bf16 exp results

---
 rtl/vector_pkg.sv | 13 +
 rtl/vexp_sum_reduce_if.sv | 29 ++
 rtl/bf16_add.sv | 101 ++++++++++
 rtl/vexp_sum_reduce.sv | 83 ++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared bf16 types and constants for the vector datapath blocks.
package vector_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_POS_ZERO = 16'h0000;
  localparam bf16_t BF16_POS_INF  = 16'h7F80;
  localparam bf16_t BF16_QNAN     = 16'h7FC0;
  localparam int    BF16_EXP_BIAS = 127;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} vsum_state_t;

endpackage

// File: rtl/vexp_sum_reduce_if.sv
// Bundle of the reduction block's signals with DUT-side and bench-side views.
interface vexp_sum_reduce_if
  import vector_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input logic CLK
);
  logic             RST;
  logic             start;
  logic [LEN_W-1:0] len;
  bf16_t            in_data;
  logic             in_valid;
  logic             in_ready;
  bf16_t            sum_out;
  logic             sum_valid;
  logic             sum_ready;
  logic             busy;

  modport dut (
    input  CLK, RST, start, len, in_data, in_valid, sum_ready,
    output in_ready, sum_out, sum_valid, busy
  );

  modport tb (
    input  CLK, in_ready, sum_out, sum_valid, busy,
    output RST, start, len, in_data, in_valid, sum_ready
  );
endinterface

// File: rtl/bf16_add.sv
// Combinational bf16 adder: flush-to-zero, round-to-nearest-even, canonical NaN.
module bf16_add
  import vector_pkg::*;
(
  input  bf16_t a,
  input  bf16_t b,
  output bf16_t y
);

  localparam logic signed [9:0] EXP_MAX = 10'(2 * BF16_EXP_BIAS + 1);

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic        big_s, sml_s, lost, guard, sticky, extra, round_up;
  logic [7:0]  big_e, sml_e, d;
  logic [6:0]  big_m, sml_m, frac;
  logic [23:0] big_f, sml_f, sml_sh, mask, norm;
  logic [24:0] sum25;
  logic [4:0]  lead_idx, sh;
  logic [8:0]  rnd;
  logic signed [9:0] exp_n, exp_r;

  always_comb begin
    a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
    b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
    a_zero = (a[14:7] == 8'h00);
    b_zero = (b[14:7] == 8'h00);

    // Order operands by magnitude so the subtraction never goes negative.
    swap  = (b[14:0] > a[14:0]);
    big_s = swap ? b[15]   : a[15];
    big_e = swap ? b[14:7] : a[14:7];
    big_m = swap ? b[6:0]  : a[6:0];
    sml_s = swap ? a[15]   : b[15];
    sml_e = swap ? a[14:7] : b[14:7];
    sml_m = swap ? a[6:0]  : b[6:0];
    d     = big_e - sml_e;

    big_f  = {1'b1, big_m, 16'h0000};
    sml_f  = {1'b1, sml_m, 16'h0000};
    mask   = (d >= 8'd24) ? {24{1'b1}} : ((24'd1 << d) - 24'd1);
    lost   = |(sml_f & mask);
    sml_sh = (sml_f >> d) | {23'd0, lost};

    sum25 = (big_s == sml_s) ? ({1'b0, big_f} + {1'b0, sml_sh})
                             : ({1'b0, big_f} - {1'b0, sml_sh});

    lead_idx = 5'd0;
    for (int i = 0; i < 25; i++) begin
      if (sum25[i]) lead_idx = 5'(i);
    end

    sh = 5'd0;
    if (sum25[24]) begin
      norm  = sum25[24:1];
      extra = sum25[0];
      exp_n = $signed({2'b00, big_e}) + 10'sd1;
    end else begin
      sh    = 5'd23 - lead_idx;
      norm  = sum25[23:0] << sh;
      extra = 1'b0;
      exp_n = $signed({2'b00, big_e}) - $signed({5'b00000, sh});
    end

    guard    = norm[15];
    sticky   = (|norm[14:0]) | extra;
    round_up = guard & (sticky | norm[16]);
    rnd      = {1'b0, norm[23:16]} + {8'd0, round_up};
    if (rnd[8]) begin
      exp_r = exp_n + 10'sd1;
      frac  = 7'd0;
    end else begin
      exp_r = exp_n;
      frac  = rnd[6:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      y = BF16_QNAN;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (a_zero && b_zero) begin
      y = {a[15] & b[15], 15'd0};
    end else if (a_zero) begin
      y = b;
    end else if (b_zero) begin
      y = a;
    end else if (sum25 == 25'd0) begin
      y = BF16_POS_ZERO;
    end else if (exp_r >= EXP_MAX) begin
      y = {big_s, BF16_POS_INF[14:0]};
    end else if (exp_r <= 10'sd0) begin
      y = {big_s, 15'd0};
    end else begin
      y = {big_s, exp_r[7:0], frac};
    end
  end

endmodule

// File: rtl/vexp_sum_reduce.sv
// Accumulates LEN bf16 exp results into one sum and offers it on a valid/ready port.
module vexp_sum_reduce
  import vector_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy
);

  vsum_state_t      state_q, state_d;
  bf16_t            acc_q, acc_d, add_y;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             accept, last_beat;

  bf16_add u_add (
    .a (acc_q),
    .b (in_data),
    .y (add_y)
  );

  assign accept    = in_valid && (state_q == ACCUM);
  assign last_beat = (cnt_q == len_q - LEN_W'(1));

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (accept && last_beat) state_d = DONE;
      DONE:    if (sum_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    sum_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sum_out   = acc_q;
  end

  // Datapath registers: latched length, beat counter and running sum.
  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    if ((state_q == IDLE) && start) begin
      len_d = len;
      cnt_d = '0;
      acc_d = BF16_POS_ZERO;
    end else if (accept) begin
      cnt_d = cnt_q + LEN_W'(1);
      acc_d = add_y;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q <= '0;
      cnt_q <= '0;
      acc_q <= BF16_POS_ZERO;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule
